// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: fetch FSM encoding,
// the NOP word, the default reset PC and a word-alignment helper.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: asynchronous active-high reset to RESET_PC,
// loads d when en is high, otherwise holds.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // PC storage with load enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_PC;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues requests to a variable-latency
// instruction memory, applies decode-stage redirects and buffers a returned
// word while the hazard unit stalls fetch.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    input  logic        jump_d,
    input  logic [31:0] pc_jump_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_f,
    output logic [31:0] pc_plus_4_f,
    output logic        valid_f,
    output logic        flush_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         pc_en_s;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic         redirect_s;
    logic [31:0]  target_s;
    logic [31:0]  pc_inc_s;

    // A stalled decode stage cannot redirect; jump takes priority over branch.
    assign redirect_s = (jump_d | pc_src_d) & ~stall_f;
    assign target_s   = align_word(jump_d ? pc_jump_d : pc_branch_d);
    assign pc_inc_s   = pc_q + 32'd4;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_en_s),
        .d   (pc_d),
        .q   (pc_q)
    );

    // Next-state, next-PC, next request address and hold-buffer selection.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_en_s     = 1'b0;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        case (state_q)
            FETCH: begin
                if (redirect_s) begin
                    pc_d    = target_s;
                    pc_en_s = 1'b1;
                    if (imem_ready) begin
                        req_addr_d = target_s;
                    end else begin
                        // Outstanding request must complete before the target is issued.
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (stall_f) begin
                        buf_instr_d = imem_rdata;
                        state_d     = HOLD;
                    end else begin
                        pc_d       = pc_inc_s;
                        pc_en_s    = 1'b1;
                        req_addr_d = pc_inc_s;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect_s) begin
                    pc_d       = target_s;
                    pc_en_s    = 1'b1;
                    req_addr_d = target_s;
                    state_d    = FETCH;
                end else if (!stall_f) begin
                    pc_d       = pc_inc_s;
                    pc_en_s    = 1'b1;
                    req_addr_d = pc_inc_s;
                    state_d    = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                if (redirect_s) begin
                    pc_d    = target_s;
                    pc_en_s = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ready) begin
                    // Abandoned word is dropped; issue the latest target next.
                    req_addr_d = pc_d;
                    state_d    = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // FSM state, request address and hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            req_addr_q  <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    // Output decode; everything is forced quiet while reset is held.
    always_comb begin
        imem_req      = 1'b0;
        valid_f       = 1'b0;
        instruction_f = NOP_INSTR;
        case (state_q)
            FETCH: begin
                imem_req = ~rst;
                valid_f  = imem_ready & ~rst;
                if (valid_f) begin
                    instruction_f = imem_rdata;
                end else begin
                    instruction_f = NOP_INSTR;
                end
            end
            HOLD: begin
                imem_req = 1'b0;
                valid_f  = ~rst;
                if (valid_f) begin
                    instruction_f = buf_instr_q;
                end else begin
                    instruction_f = NOP_INSTR;
                end
            end
            DRAIN: begin
                imem_req      = ~rst;
                valid_f       = 1'b0;
                instruction_f = NOP_INSTR;
            end
            default: begin
                imem_req      = 1'b0;
                valid_f       = 1'b0;
                instruction_f = NOP_INSTR;
            end
        endcase
    end

    assign imem_addr   = req_addr_q;
    assign pc_plus_4_f = pc_q + 32'd4;
    assign flush_d     = redirect_s & ~rst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a main instance with RESET_PC=0 and a
// second instance with RESET_PC=FFFF_FFFC for the wrap-around case. The
// memory model returns addr>>2 as the instruction word.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        pc_src_d;
    logic [31:0] pc_branch_d;
    logic        jump_d;
    logic [31:0] pc_jump_d;
    logic        imem_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_f;
    logic [31:0] pc_plus_4_f;
    logic        valid_f;
    logic        flush_d;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_instruction_f;
    logic [31:0] w_pc_plus_4_f;
    logic        w_valid_f;
    logic        w_flush_d;

    int checks = 0;
    int errors = 0;

    assign imem_rdata   = imem_addr >> 2;
    assign w_imem_rdata = w_imem_addr >> 2;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f),
        .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
        .jump_d(jump_d), .pc_jump_d(pc_jump_d),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction_f(instruction_f), .pc_plus_4_f(pc_plus_4_f),
        .valid_f(valid_f), .flush_d(flush_d)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall_f(stall_f),
        .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
        .jump_d(jump_d), .pc_jump_d(pc_jump_d),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ready(imem_ready), .imem_rdata(w_imem_rdata),
        .instruction_f(w_instruction_f), .pc_plus_4_f(w_pc_plus_4_f),
        .valid_f(w_valid_f), .flush_d(w_flush_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        stall_f     = 1'b0;
        pc_src_d    = 1'b0;
        pc_branch_d = 32'h0;
        jump_d      = 1'b0;
        pc_jump_d   = 32'h0;
        imem_ready  = 1'b1;
        #2;
        // Reset state: outputs quiet even with ready high
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid_f},  32'd0);
        chk("rst_flush", {31'd0, flush_d},  32'd0);
        chk("rst_instr", instruction_f,     32'h0);
        chk("rst_addr",  imem_addr,         32'h0);
        chk("rst_wreq",  {31'd0, w_imem_req}, 32'd0);
        chk("rst_wflush", {31'd0, w_flush_d}, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        // Zero-wait run
        chk("zw0_req",   {31'd0, imem_req}, 32'd1);
        chk("zw0_addr",  imem_addr,         32'h0);
        chk("zw0_valid", {31'd0, valid_f},  32'd1);
        chk("zw0_pc4",   pc_plus_4_f,       32'h4);
        chk("wrap_addr0", w_imem_addr,      32'hFFFF_FFFC);
        chk("wrap_pc4",   w_pc_plus_4_f,    32'h0);
        chk("wrap_instr", w_instruction_f,  32'h3FFF_FFFF);
        chk("wrap_valid", {31'd0, w_valid_f}, 32'd1);
        tick();
        chk("zw1_addr",  imem_addr,     32'h4);
        chk("zw1_instr", instruction_f, 32'h1);
        chk("zw1_pc4",   pc_plus_4_f,   32'h8);
        chk("wrap_addr1", w_imem_addr,  32'h0);
        tick();
        chk("zw2_addr",  imem_addr,     32'h8);
        chk("zw2_instr", instruction_f, 32'h2);
        chk("zw2_pc4",   pc_plus_4_f,   32'hC);
        tick();
        chk("zw3_addr",  imem_addr,     32'hC);
        chk("zw3_instr", instruction_f, 32'h3);
        chk("zw3_pc4",   pc_plus_4_f,   32'h10);

        // Two wait states on the request to 0xC
        imem_ready = 1'b0;
        #1;
        chk("ws0_addr",  imem_addr,        32'hC);
        chk("ws0_valid", {31'd0, valid_f}, 32'd0);
        chk("ws0_instr", instruction_f,    32'h0);
        tick();
        chk("ws1_addr",  imem_addr,        32'hC);
        chk("ws1_req",   {31'd0, imem_req}, 32'd1);
        chk("ws1_valid", {31'd0, valid_f}, 32'd0);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("ws2_addr",  imem_addr,        32'hC);
        chk("ws2_valid", {31'd0, valid_f}, 32'd1);
        chk("ws2_instr", instruction_f,    32'h3);
        tick();
        chk("ws3_addr",  imem_addr,        32'h10);

        // Stall for 3 cycles while the 0x10 word returns
        stall_f = 1'b1;
        #1;
        chk("st0_valid", {31'd0, valid_f}, 32'd1);
        chk("st0_instr", instruction_f,    32'h4);
        tick();
        chk("st1_req",   {31'd0, imem_req}, 32'd0);
        chk("st1_valid", {31'd0, valid_f}, 32'd1);
        chk("st1_instr", instruction_f,    32'h4);
        chk("st1_pc4",   pc_plus_4_f,      32'h14);
        tick();
        chk("st2_req",   {31'd0, imem_req}, 32'd0);
        chk("st2_instr", instruction_f,    32'h4);
        // Branch request under stall is ignored
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0080;
        #1;
        chk("st2_noflush", {31'd0, flush_d}, 32'd0);
        pc_src_d = 1'b0;
        tick();
        stall_f = 1'b0;
        #1;
        chk("st3_instr", instruction_f,    32'h4);
        chk("st3_valid", {31'd0, valid_f}, 32'd1);
        tick();
        chk("st4_addr",  imem_addr,        32'h14);
        chk("st4_req",   {31'd0, imem_req}, 32'd1);
        chk("st4_instr", instruction_f,    32'h5);

        // Taken branch to 0x41 (aligned to 0x40)
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0041;
        #1;
        chk("br_flush", {31'd0, flush_d}, 32'd1);
        tick();
        pc_src_d = 1'b0;
        #1;
        chk("br_flush_off", {31'd0, flush_d}, 32'd0);
        chk("br_addr",  imem_addr,     32'h40);
        chk("br_valid", {31'd0, valid_f}, 32'd1);
        chk("br_instr", instruction_f, 32'h10);
        chk("br_pc4",   pc_plus_4_f,   32'h44);

        // Jump to 0x20
        jump_d    = 1'b1;
        pc_jump_d = 32'h0000_0020;
        #1;
        chk("jp_flush", {31'd0, flush_d}, 32'd1);
        tick();
        jump_d = 1'b0;
        #1;
        chk("jp_addr", imem_addr, 32'h20);

        // Redirect while 0x20 is pending; jump and branch together -> jump target
        imem_ready  = 1'b0;
        jump_d      = 1'b1;
        pc_jump_d   = 32'h0000_0100;
        pc_src_d    = 1'b1;
        pc_branch_d = 32'h0000_0200;
        #1;
        chk("dr0_flush", {31'd0, flush_d}, 32'd1);
        chk("dr0_valid", {31'd0, valid_f}, 32'd0);
        chk("dr0_addr",  imem_addr,        32'h20);
        tick();
        jump_d   = 1'b0;
        pc_src_d = 1'b0;
        #1;
        chk("dr1_addr",  imem_addr,        32'h20);
        chk("dr1_req",   {31'd0, imem_req}, 32'd1);
        chk("dr1_valid", {31'd0, valid_f}, 32'd0);
        chk("dr1_pc4",   pc_plus_4_f,      32'h104);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("dr2_addr",  imem_addr,        32'h20);
        chk("dr2_valid", {31'd0, valid_f}, 32'd0);
        chk("dr2_instr", instruction_f,    32'h0);
        tick();
        chk("dr3_addr",  imem_addr,        32'h100);
        chk("dr3_valid", {31'd0, valid_f}, 32'd1);
        chk("dr3_instr", instruction_f,    32'h40);
        tick();
        chk("dr4_addr",  imem_addr,        32'h104);

        // Reset asserted mid-wait
        imem_ready = 1'b0;
        tick();
        chk("mr0_addr", imem_addr, 32'h104);
        rst        = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("mr_req",   {31'd0, imem_req}, 32'd0);
        chk("mr_valid", {31'd0, valid_f},  32'd0);
        chk("mr_instr", instruction_f,     32'h0);
        chk("mr_addr",  imem_addr,         32'h0);
        chk("mr_waddr", w_imem_addr,       32'hFFFF_FFFC);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_rel_req",  {31'd0, imem_req}, 32'd1);
        chk("mr_rel_addr", imem_addr,         32'h0);
        chk("mr_rel_waddr", w_imem_addr,      32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the IF/ID register (`reg_d`). It holds the PC and drives requests to a variable-latency instruction memory. It delivers `instruction_f` / `pc_plus_4_f` with a valid flag to `reg_d`, and applies branch/jump redirects resolved in decode. It also generates the decode-register clear on redirect and buffers a returned instruction while the hazard unit stalls fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall_f` input 1: hazard-unit stall; hold the PC and the presented instruction.
- `pc_src_d` input 1: branch taken, resolved in decode.
- `pc_branch_d` input 32: branch target.
- `jump_d` input 1: jump in decode.
- `pc_jump_d` input 32: jump target.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: word-aligned fetch address.
- `imem_ready` input 1: memory returns data this cycle.
- `imem_rdata` input 32: instruction word, valid when `imem_ready`=1.
- `instruction_f` output 32: instruction to `reg_d.instruction_in`.
- `pc_plus_4_f` output 32: address of `instruction_f` + 4, to `reg_d.pc_plus_4_in`.
- `valid_f` output 1: `instruction_f` is valid this cycle.
- `flush_d` output 1: clear for `reg_d.clr`.

## Operation
- State registers: `pc`, `req_addr`, `buf_instr`, and FSM state FETCH / HOLD / DRAIN.
- **Redirect** is `(jump_d | pc_src_d) & ~stall_f`.
  - Target is `pc_jump_d` if `jump_d`, else `pc_branch_d`. Jump wins if both are asserted.
  - Target bits [1:0] are forced to 00.
  - `flush_d` = redirect, combinational.
- **FETCH**
  - Outputs: `imem_req`=1, `imem_addr`=`req_addr`.
  - On `imem_ready`: `valid_f`=1 and `instruction_f`=`imem_rdata`.
  - `imem_ready` & ~`stall_f` & ~redirect: `pc` and `req_addr` become `pc`+4; stay in FETCH.
  - `imem_ready` & `stall_f`: capture `imem_rdata` into `buf_instr`; go to HOLD; `pc` is unchanged.
  - Redirect with `imem_ready`=1: `pc` and `req_addr` become the target; stay in FETCH. The returned word is dropped.
  - Redirect with `imem_ready`=0: `pc` becomes the target; `req_addr` keeps the old address; go to DRAIN.
  - While waiting, `imem_addr` and `imem_req` stay stable until `imem_ready`.
- **HOLD**
  - Outputs: `imem_req`=0, `valid_f`=1, `instruction_f`=`buf_instr`.
  - When `stall_f` falls: `pc`/`req_addr` become `pc`+4; go to FETCH.
  - Redirect in HOLD: `pc`/`req_addr` become the target; go to FETCH.
- **DRAIN**
  - Outputs: `imem_req`=1 on the old `req_addr`, `valid_f`=0.
  - On `imem_ready`: discard the data, `req_addr` becomes `pc`, go to FETCH.
  - A further redirect in DRAIN updates only `pc`.
- `pc_plus_4_f` = `pc`+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- When `valid_f`=0, `instruction_f` = 32'h0000_0000 (NOP).
- `reg_d.enable` must be driven as `~stall_f & valid_f`.

## Timing
- **Reset** (asynchronous, asserted at any time, including mid-request):
  - `pc`=`req_addr`=`RESET_PC`, state=FETCH, `buf_instr`=0.
  - While `rst`=1: `imem_req`=0, `valid_f`=0, `flush_d`=0, `instruction_f`=0.
  - Any outstanding request is abandoned; instruction memory is reset in the same domain.
  - First request is issued in the first cycle after `rst` deasserts.
- **Throughput:** a zero-wait memory (`imem_ready` tied to 1) gives one instruction per cycle.
- **Wait states:** an N-wait memory gives one instruction per N+1 cycles.
- **Redirect penalty:**
  - Target appears on `imem_addr` in the cycle after redirect.
  - With zero-wait memory, the target instruction has `valid_f`=1 one cycle after redirect.
  - DRAIN adds the remaining latency of the abandoned request.
- All outputs except `flush_d` and the FETCH `instruction_f`/`valid_f` pass-through are functions of registered state.

## Structure
- Shared package `mips_pkg` holds:
  - FSM state encoding: FETCH=2'd0, HOLD=2'd1, DRAIN=2'd2.
  - `NOP_INSTR`=32'h0.
  - The default `RESET_PC`.
- One sub-module, `pc_reg`: 32-bit register with async active-high reset to `RESET_PC`, load enable, and data input.
- Redirect mux and FSM live in the top level.

## Test plan
- **Reset and zero-wait run:** `rst` pulse, `imem_ready`=1, memory returns addr>>2 → `imem_addr` 0,4,8,C on consecutive cycles; `valid_f`=1 each cycle; `pc_plus_4_f` 4,8,C,10.
- **Wait states:** `imem_ready` low for 2 cycles per request → `imem_addr` held 3 cycles; `valid_f` pulses once per 3 cycles; no address skips.
- **Stall:** `stall_f`=1 for 3 cycles while the word at 0x8 returns → HOLD, `imem_req`=0, `instruction_f` stable at the 0x8 word; after release, next `imem_addr`=0xC.
- **Branch:** `pc_src_d`=1, `pc_branch_d`=0x40 → `flush_d`=1 that cycle; next `imem_addr`=0x40; no instruction from pc+4 is validated.
- **Redirect during wait:** redirect to 0x100 while a request to 0x20 is pending → `imem_addr` stays 0x20 until ready, data discarded (`valid_f`=0), then `imem_addr`=0x100; jump+branch together selects `pc_jump_d`.
- **Wrap and mid-request reset:**
  - `RESET_PC`=32'hFFFF_FFFC → `pc_plus_4_f`=0 and next address 0.
  - `rst` asserted mid-wait → outputs zero immediately; after release, `imem_addr`=`RESET_PC`.
